// File: rtl/icache_pkg.sv
// Shared definitions for the instruction-cache fetch responder.
//   state_e        : controller states (idle lookup, line refill, refill-complete)
//   NOP_INSTR_DEF  : default instruction driven while stalled or in reset (addi x0,x0,0)
//   off_w/idx_w/tag_w : address-field widths derived from LINES and WPL
package icache_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRefill = 2'd1,
    StDone   = 2'd2
  } state_e;

  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

  // Word-offset bits within a line.
  function automatic int unsigned off_w(input int unsigned wpl);
    return $clog2(wpl);
  endfunction

  // Line-index bits.
  function automatic int unsigned idx_w(input int unsigned lines);
    return $clog2(lines);
  endfunction

  // Tag bits: everything above index and offset, excluding the byte bits [1:0].
  function automatic int unsigned tag_w(input int unsigned lines, input int unsigned wpl);
    return 30 - off_w(wpl) - idx_w(lines);
  endfunction

endpackage

// File: rtl/icache_data_array.sv
// Instruction cache data storage: LINES*WPL words of 32 bits.
// Ports:
//   clk   : write clock (rising edge)
//   we    : write enable
//   waddr : write word address {line index, word offset}
//   wdata : write data
//   raddr : read word address {line index, word offset}
//   rdata : combinational read data
// Contents are not reset; validity is tracked by the controller.
module icache_data_array #(
  parameter int unsigned LINES = 16,
  parameter int unsigned WPL   = 4
) (
  input  logic                               clk,
  input  logic                               we,
  input  logic [$clog2(LINES*WPL)-1:0]       waddr,
  input  logic [31:0]                        wdata,
  input  logic [$clog2(LINES*WPL)-1:0]       raddr,
  output logic [31:0]                        rdata
);

  localparam int unsigned DEPTH = LINES * WPL;

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/icache_fetch.sv
// Direct-mapped instruction cache answering a single-cycle core's fetch port.
// Hits return the instruction in the same cycle; misses stall the core while the
// line is refilled word-by-word from backing memory over a req/valid handshake.
// Ports:
//   clk, RST            : clock (rising edge), asynchronous active-low reset
//   PC                  : byte fetch address (bits [1:0] ignored)
//   Instr, stall        : fetched instruction; stall high while Instr is not valid
//   flush               : invalidate all lines (fence.i)
//   mem_req, mem_addr   : backing-memory word read request and word-aligned address
//   mem_valid, mem_rdata: completes the current request with its data
//   hit_cnt, miss_cnt   : lookup statistics, present only when ICACHE_STATS_EN is defined
module icache_fetch
  import icache_pkg::*;
#(
  parameter int unsigned LINES     = 16,
  parameter int unsigned WPL       = 4,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [31:0] PC,
  output logic [31:0] Instr,
  output logic        stall,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_valid,
  input  logic [31:0] mem_rdata
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int unsigned OFF_W  = off_w(WPL);
  localparam int unsigned IDX_W  = idx_w(LINES);
  localparam int unsigned TAG_W  = tag_w(LINES, WPL);
  localparam int unsigned LINE_W = TAG_W + IDX_W;
  localparam int unsigned AW     = IDX_W + OFF_W;

  // Lookup fields from the live PC
  logic [OFF_W-1:0]  pc_off;
  logic [LINE_W-1:0] pc_line;
  logic [IDX_W-1:0]  pc_idx;
  logic [TAG_W-1:0]  pc_tag;
  logic              unused_pc_lsb;

  assign pc_off        = PC[OFF_W+1:2];
  assign pc_line       = PC[31:OFF_W+2];
  assign pc_idx        = pc_line[IDX_W-1:0];
  assign pc_tag        = pc_line[LINE_W-1:IDX_W];
  assign unused_pc_lsb = ^PC[1:0];

  // State
  state_e            state_q, state_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q [LINES];
  logic [LINE_W-1:0] line_q, line_d;     // {tag, index} of the line being refilled
  logic [OFF_W-1:0]  cnt_q, cnt_d;
  logic              mem_req_q, mem_req_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic              flush_pend_q, flush_pend_d;

  logic [IDX_W-1:0]  ref_idx;
  logic [TAG_W-1:0]  ref_tag;
  logic              hit;
  logic              word_ack;
  logic              last_word;
  logic              tag_we;
  logic [31:0]       rd_data;

  // Refill works from the latched line, never from the live PC.
  assign ref_idx   = line_q[IDX_W-1:0];
  assign ref_tag   = line_q[LINE_W-1:IDX_W];
  assign hit       = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
  assign word_ack  = (state_q == StRefill) && mem_req_q && mem_valid;
  assign last_word = (cnt_q == OFF_W'(WPL - 1));

  icache_data_array #(
    .LINES (LINES),
    .WPL   (WPL)
  ) u_data (
    .clk   (clk),
    .we    (word_ack),
    .waddr ({ref_idx, cnt_q}),
    .wdata (mem_rdata),
    .raddr (AW'({pc_idx, pc_off})),
    .rdata (rd_data)
  );

  // State register
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q      <= StIdle;
      valid_q      <= '0;
      line_q       <= '0;
      cnt_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      line_q       <= line_d;
      cnt_q        <= cnt_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  always_ff @(posedge clk) begin
    if (tag_we) begin
      tag_q[ref_idx] <= ref_tag;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (!hit) state_d = StRefill;
      StRefill: if (word_ack && last_word) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Refill datapath, valid bits and deferred flush
  always_comb begin
    line_d       = line_q;
    cnt_d        = cnt_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    valid_d      = valid_q;
    flush_pend_d = flush_pend_q;
    tag_we       = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Flush clears first; a concurrent miss still fills and validates its line.
        if (flush) valid_d = '0;
        if (!hit) begin
          line_d     = pc_line;
          cnt_d      = '0;
          mem_req_d  = 1'b1;
          mem_addr_d = {pc_line, {OFF_W{1'b0}}, 2'b00};
        end
      end
      StRefill: begin
        if (flush) flush_pend_d = 1'b1;
        if (word_ack) begin
          cnt_d = cnt_q + OFF_W'(1);
          if (last_word) begin
            mem_req_d        = 1'b0;
            tag_we           = 1'b1;
            valid_d[ref_idx] = 1'b1;
          end else begin
            mem_addr_d = {line_q, cnt_q + OFF_W'(1), 2'b00};
          end
        end
      end
      StDone: begin
        // Deferred flush lands on the return to idle, taking the new line with it.
        if (flush || flush_pend_q) valid_d = '0;
        flush_pend_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Outputs; reset forces the quiet values asynchronously.
  always_comb begin
    stall = 1'b0;
    Instr = NOP_INSTR;
    if (RST) begin
      unique case (state_q)
        StIdle: begin
          stall = !hit;
          if (hit) Instr = rd_data;
        end
        StRefill, StDone: stall = 1'b1;
        default:          stall = 1'b1;
      endcase
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == StIdle) begin
      if (hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
      else     miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule
